// File: rtl/bp_gshare_lookup.sv
// Fetch-side gshare branch predictor: 2-bit PHT, untagged BTB and global history,
// with a one-cycle registered lookup and write-first bypass from the branch unit.
module bp_gshare_lookup #(
    parameter int         IDX_BITS = 8,
    parameter logic [1:0] PHT_INIT = 2'b01
) (
    input  logic                clk,
    input  logic                rst,
    output logic                ready,
    input  logic                fetch_valid,
    input  logic                fetch_stall,
    input  logic [31:0]         fetch_pc,
    input  logic                flush,
    output logic                pred_valid,
    output logic [31:0]         pred_pc,
    output logic                pred_bp,
    output logic [31:0]         pred_bp_addr,
    output logic [IDX_BITS-1:0] pred_gshare,
    output logic [1:0]          pred_pht_value,
    input  logic                btb_web,
    input  logic [IDX_BITS-1:0] btb_addr,
    input  logic [31:0]         btb_din,
    input  logic                pht_web,
    input  logic [IDX_BITS-1:0] pht_addr,
    input  logic [1:0]          pht_in,
    input  logic                branch_taken
);

    localparam int ENTRIES = 1 << IDX_BITS;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t              r_state;
    logic [IDX_BITS-1:0] r_init_cnt;
    logic [IDX_BITS-1:0] r_ghr;

    logic [1:0]          r_pht     [ENTRIES];
    logic [31:0]         r_btb_tgt [ENTRIES];
    logic [ENTRIES-1:0]  r_btb_v;

    logic                r_ready;
    logic                r_pred_valid_p1;
    logic [31:0]         r_pred_pc_p1;
    logic                r_pred_bp_p1;
    logic [31:0]         r_pred_bp_addr_p1;
    logic [IDX_BITS-1:0] r_pred_gshare_p1;
    logic [1:0]          r_pred_pht_p1;

    logic [IDX_BITS-1:0] w_bidx;
    logic [IDX_BITS-1:0] w_idx;
    logic                w_run;
    logic                w_pht_wr;
    logic                w_btb_wr;
    logic                w_lookup;
    logic [1:0]          w_pht_rd;
    logic                w_btb_v_rd;
    logic [31:0]         w_btb_tgt_rd;
    logic                w_bp;
    logic [31:0]         w_bp_addr;
    logic                w_unused_pc;

    // Stage 0: index formation and write-first array read
    assign w_bidx      = fetch_pc[IDX_BITS+1:2];
    assign w_idx       = w_bidx ^ r_ghr;
    assign w_unused_pc = ^{fetch_pc[31:IDX_BITS+2], fetch_pc[1:0]};

    assign w_run    = (r_state == ST_RUN);
    assign w_pht_wr = w_run && !pht_web;
    assign w_btb_wr = w_run && !btb_web;
    assign w_lookup = w_run && fetch_valid && !fetch_stall && !flush;

    assign w_pht_rd     = (w_pht_wr && (pht_addr == w_idx))  ? pht_in  : r_pht[w_idx];
    assign w_btb_v_rd   = (w_btb_wr && (btb_addr == w_bidx)) ? 1'b1    : r_btb_v[w_bidx];
    assign w_btb_tgt_rd = (w_btb_wr && (btb_addr == w_bidx)) ? btb_din : r_btb_tgt[w_bidx];

    assign w_bp      = w_btb_v_rd & w_pht_rd[1];
    assign w_bp_addr = w_bp ? w_btb_tgt_rd : 32'd0;

    // Arrays are only cleared through the init sweep, never by reset directly
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == ST_INIT) begin
                r_pht[r_init_cnt]   <= PHT_INIT;
                r_btb_v[r_init_cnt] <= 1'b0;
            end else begin
                if (w_pht_wr) begin
                    r_pht[pht_addr] <= pht_in;
                end
                if (w_btb_wr) begin
                    r_btb_tgt[btb_addr] <= btb_din;
                    r_btb_v[btb_addr]   <= 1'b1;
                end
            end
        end
    end

    // Stage 1: control FSM, history and registered prediction
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state           <= ST_INIT;
            r_init_cnt        <= '0;
            r_ghr             <= '0;
            r_ready           <= 1'b0;
            r_pred_valid_p1   <= 1'b0;
            r_pred_pc_p1      <= '0;
            r_pred_bp_p1      <= 1'b0;
            r_pred_bp_addr_p1 <= '0;
            r_pred_gshare_p1  <= '0;
            r_pred_pht_p1     <= '0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_init_cnt <= r_init_cnt + 1'b1;
                    if (r_init_cnt == {IDX_BITS{1'b1}}) begin
                        r_state <= ST_RUN;
                        r_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_pht_wr) begin
                        r_ghr <= {r_ghr[IDX_BITS-2:0], branch_taken};
                    end
                    if (flush) begin
                        r_pred_valid_p1 <= 1'b0;
                    end else if (!fetch_stall) begin
                        r_pred_valid_p1 <= fetch_valid;
                    end
                    if (w_lookup) begin
                        r_pred_pc_p1      <= fetch_pc;
                        r_pred_bp_p1      <= w_bp;
                        r_pred_bp_addr_p1 <= w_bp_addr;
                        r_pred_gshare_p1  <= w_idx;
                        r_pred_pht_p1     <= w_pht_rd;
                    end
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

    assign ready          = r_ready;
    assign pred_valid     = r_pred_valid_p1;
    assign pred_pc        = r_pred_pc_p1;
    assign pred_bp        = r_pred_bp_p1;
    assign pred_bp_addr   = r_pred_bp_addr_p1;
    assign pred_gshare    = r_pred_gshare_p1;
    assign pred_pht_value = r_pred_pht_p1;

endmodule

// File: doc/bp_gshare_lookup.md
Name: bp_gshare_lookup

Overview:
- Fetch-side branch predictor: the read end of the BTB/PHT update interface that the branch functional unit drives.
- Holds a 256-entry 2-bit PHT, a 256-entry BTB (target and valid) and a global history register (GHR).
- Each fetch PC yields, one cycle later, the prediction fields carried in decode_info: bp, bp_addr, gshare, pht_value.
- Absorbs the branch unit's active-low write strobes and keeps its own history.

Parameters:
- IDX_BITS, 8, index width for PHT, BTB and GHR (256 entries each).
- PHT_INIT, 2'b01, counter value written to every PHT entry by the init sweep (weakly not-taken).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ready  out  1  high once the init sweep completes; fetch must not present PCs while low
- fetch_valid  in  1  fetch_pc is presented this cycle
- fetch_stall  in  1  downstream stall; hold stage-1 outputs
- fetch_pc  in  32  PC being fetched
- flush  in  1  pipeline redirect; kill stage-1 prediction
- pred_valid  out  1  stage-1 prediction valid
- pred_pc  out  32  PC the prediction belongs to
- pred_bp  out  1  predicted taken
- pred_bp_addr  out  32  predicted target (0 when pred_bp=0)
- pred_gshare  out  8  PHT index used; returned later on pht_addr
- pred_pht_value  out  2  PHT counter read at pred_gshare
- btb_web  in  1  active-low BTB write enable
- btb_addr  in  8  BTB write index (pc[9:2])
- btb_din  in  32  BTB target
- pht_web  in  1  active-low PHT write enable
- pht_addr  in  8  PHT write index
- pht_in  in  2  new counter value
- branch_taken  in  1  resolved outcome; shifted into the GHR on every PHT write

Behaviour:
- FSM states: INIT, RUN. rst forces INIT, init_cnt=0, ghr=0, and all outputs 0 (ready=0, pred_valid=0, pred fields 0).
- INIT:
  - Each cycle: pht[init_cnt]<=PHT_INIT, btb_v[init_cnt]<=0, init_cnt++.
  - At init_cnt==255, write that entry and go to RUN; ready=1 from the next cycle. Sweep is 256 cycles.
  - fetch_valid and all write ports are ignored in INIT.
- rst asserted mid-RUN or mid-INIT restarts the sweep from entry 0.
- RUN lookup:
  - When fetch_valid && !fetch_stall: idx=fetch_pc[9:2]^ghr, bidx=fetch_pc[9:2], both arrays read.
  - Next cycle: pred_valid=1, pred_pc=fetch_pc, pred_gshare=idx, pred_pht_value=pht[idx].
  - pred_bp = btb_v[bidx] & pht[idx][1]; pred_bp_addr = pred_bp ? btb_tgt[bidx] : 0.
  - Latency is exactly 1 cycle.
- fetch_valid=0 with no stall: pred_valid=0 next cycle.
- fetch_stall=1: all stage-1 outputs and the registered state hold; a new fetch_pc is not captured.
- flush=1: pred_valid=0 next cycle, overriding stall and fetch_valid. The array contents and the GHR are not changed by flush.
- Writes, RUN only, take effect at the clock edge:
  - !btb_web: btb_tgt[btb_addr]<=btb_din, btb_v[btb_addr]<=1.
  - !pht_web: pht[pht_addr]<=pht_in, ghr<={ghr[6:0],branch_taken}.
- GHR updates non-speculatively at resolution only.
- Same-cycle read/write:
  - Write-first bypass: a lookup whose idx==pht_addr (or bidx==btb_addr) during an active write sees the new data.
  - The lookup uses the pre-update GHR.
- BTB has no tag; aliasing PCs share entries by design.
- All index arithmetic is 8-bit XOR with no carry. pc[1:0] and pc[31:10] are unused for indexing.

Test Plan:
- Reset: rst 1 cycle -> ready=0 for 256 cycles, then 1; lookup of pc 0x100 -> pred_pht_value=01, pred_bp=0, pred_bp_addr=0, pred_gshare=0x40.
- Train: pht_web=0, pht_addr=0x40, pht_in=11, branch_taken=1; btb_web=0, btb_addr=0x40, btb_din=0x200 -> ghr=0x01; next lookup of 0x100 -> gshare=0x41, pht 01, bp=0. Then write pht[0x41]=10 -> lookup of 0x100 (ghr=0x03) -> gshare 0x43.
- Bypass: lookup 0x104 (idx 0x41^ghr) in the same cycle as a PHT write to that idx with 11 and a BTB write to 0x41 with 0x300 -> pred_bp=1, pred_bp_addr=0x300.
- Stall: present 0x100 then 0x108 with fetch_stall=1 -> pred_pc stays 0x100 until the stall drops, then 0x108 one cycle later.
- Flush: present 0x100 with flush=1 in the next cycle -> pred_valid=0; ghr and arrays unchanged.
- Reset mid-RUN after training -> sweep re-runs; lookup of 0x100 returns pht 01, bp=0, ghr=0.
